sampq_fifo: RTL and testbench

Sample queue buffer downstream of the ADC accumulator. Captures 32-bit sample words on `sample_avail`, stores them in an on-chip FIFO and drains them as a little-endian byte stream to the host transport. Also owns the queue run state: it drives `sq_active` to all producers and reports overflow and fill level over the Wishbone command bus.

---
 rtl/sampq_pkg.sv | 12 +
 rtl/sampq_ram.sv | 19 +
 rtl/sampq_fifo.sv | 115 +++++++++++
 tb/tb_sampq_fifo.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sampq_pkg.sv
// sampq_pkg: register map, status/control bit positions and serializer states for sampq_fifo
package sampq_pkg;
  localparam logic [1:0] SQ_REG_STATUS = 2'd0;
  localparam logic [1:0] SQ_REG_FILL = 2'd1;
  localparam logic [1:0] SQ_REG_OVF_LO = 2'd2;
  localparam logic [1:0] SQ_REG_OVF_HI = 2'd3;
  localparam int SQ_ST_ACTIVE = 0;
  localparam int SQ_ST_OVF = 1;
  localparam int SQ_CTL_RUN = 0;
  localparam int SQ_CTL_FLUSH = 1;
  typedef enum logic [1:0] {SQ_IDLE, SQ_LOAD, SQ_SEND} sq_state_e;
endpackage

// File: rtl/sampq_ram.sv
// sampq_ram: simple dual-port RAM with synchronous read, no reset, block-RAM inferable
module sampq_ram #(
  parameter int ADDR_BITS = 9,
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data
);
  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/sampq_fifo.sv
// sampq_fifo: sample word FIFO drained as a little-endian byte stream, with Wishbone run/flush/status control.
// Optional SAMPQ_OVERFLOW_COUNT_EN builds a 16-bit saturating dropped-word counter on addresses 2/3.
module sampq_fifo
  import sampq_pkg::*;
#(
  parameter int ADDR_BITS = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] sample,
  input  logic        sample_avail,
  output logic        sq_active,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [15:0] wb_adr_i,
  input  logic [7:0]  wb_dat_i,
  output logic [7:0]  wb_dat_o,
  output logic        wb_ack_o
);
  localparam logic [ADDR_BITS-1:0] FILL_SAT = ADDR_BITS'(255);
  logic [ADDR_BITS:0] wr_ptr, rd_ptr, fill;
  logic [ADDR_BITS-1:0] fill_half;
  logic [7:0] fill_rd, status, ovf_lo, ovf_hi;
  logic [31:0] shift, rd_data;
  logic [1:0] idx;
  logic ctl_wr, activate, flush, full, empty, push, drop, pop, accept, overflow, unused_bits;
  sq_state_e state, state_nx;
  assign ctl_wr = wb_cyc_i && wb_stb_i && wb_we_i && wb_adr_i[1:0] == SQ_REG_STATUS;
  assign activate = ctl_wr && wb_dat_i[SQ_CTL_RUN] && !sq_active;
  assign flush = ctl_wr && wb_dat_i[SQ_CTL_FLUSH] && (!sq_active || !wb_dat_i[SQ_CTL_RUN]);
  assign fill = wr_ptr - rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full = wr_ptr[ADDR_BITS] != rd_ptr[ADDR_BITS] && wr_ptr[ADDR_BITS-1:0] == rd_ptr[ADDR_BITS-1:0];
  assign push = sample_avail && !full;
  assign drop = sample_avail && full;
  assign pop = state == SQ_IDLE && !empty;
  assign accept = state == SQ_SEND && out_ready;
  assign out_valid = state == SQ_SEND;
  assign out_data = shift[7:0];
  assign wb_ack_o = 1'b1;
  assign unused_bits = ^{wb_adr_i[15:2], wb_dat_i[7:2], fill[0]};
  sampq_ram #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(32)) u_ram (
    .clk(clk),
    .wr_en(push),
    .wr_addr(wr_ptr[ADDR_BITS-1:0]),
    .wr_data(sample),
    .rd_en(pop),
    .rd_addr(rd_ptr[ADDR_BITS-1:0]),
    .rd_data(rd_data)
  );
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) sq_active <= 1'b0;
    else if (ctl_wr) sq_active <= wb_dat_i[SQ_CTL_RUN];
  end
  // re-arming the queue wins over a drop in the same cycle
  always_ff @(posedge clk) begin
    if (rst || activate) overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end
`ifdef SAMPQ_OVERFLOW_COUNT_EN
  logic [15:0] ovf_cnt;
  always_ff @(posedge clk) begin
    if (rst || activate) ovf_cnt <= '0;
    else if (drop && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
  end
  assign ovf_lo = ovf_cnt[7:0];
  assign ovf_hi = ovf_cnt[15:8];
`else
  assign ovf_lo = '0;
  assign ovf_hi = '0;
`endif
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= SQ_IDLE;
      shift <= '0;
      idx <= '0;
    end else begin
      state <= state_nx;
      if (state == SQ_LOAD) begin
        shift <= rd_data;
        idx <= '0;
      end else if (accept) begin
        shift <= shift >> 8;
        idx <= idx + 2'd1;
      end
    end
  end
  always_comb begin
    state_nx = state;
    state_nx = pop ? SQ_LOAD : state == SQ_LOAD ? SQ_SEND : (accept && idx == 2'd3) ? SQ_IDLE : state;
  end
  always_comb begin
    fill_half = fill[ADDR_BITS:1];
    fill_rd = fill_half > FILL_SAT ? 8'hFF : 8'(fill_half);
    status = '0;
    status[SQ_ST_ACTIVE] = sq_active;
    status[SQ_ST_OVF] = overflow;
    wb_dat_o = wb_adr_i[1:0] == SQ_REG_STATUS ? status :
               wb_adr_i[1:0] == SQ_REG_FILL ? fill_rd :
               wb_adr_i[1:0] == SQ_REG_OVF_LO ? ovf_lo : ovf_hi;
  end
endmodule

// File: tb/tb_sampq_fifo.sv
// tb_sampq_fifo: directed stimulus with a byte scoreboard drained by an independent output monitor
module tb_sampq_fifo;
  localparam int AB = 9;
  localparam int DEPTH = 1 << AB;
  logic clk = 0, rst = 1, sample_avail = 0, out_ready = 0;
  logic wb_stb_i = 0, wb_cyc_i = 0, wb_we_i = 0;
  logic [31:0] sample = 0;
  logic [15:0] wb_adr_i = 0;
  logic [7:0] wb_dat_i = 0, wb_dat_o, out_data;
  logic sq_active, out_valid, wb_ack_o;
  logic [7:0] exp_q[$];
  logic [7:0] held;
  logic stalled;
  int checks = 0, failures = 0;
  sampq_fifo #(.ADDR_BITS(AB)) dut (
    .clk(clk), .rst(rst), .sample(sample), .sample_avail(sample_avail),
    .sq_active(sq_active), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask
  initial begin
    stalled = 0;
    held = 0;
    forever begin
      @(negedge clk);
      if (rst) stalled = 0;
      else begin
        if (stalled && out_valid) check("stall_hold", out_data, held);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_byte actual=0x%0h expected=none", out_data);
          end else check("stream_byte", out_data, exp_q.pop_front());
        end
        stalled = out_valid && !out_ready;
        held = out_data;
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push_word(input logic [31:0] w, input bit kept);
    sample = w;
    sample_avail = 1;
    if (kept) begin
      exp_q.push_back(w[7:0]);
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[23:16]);
      exp_q.push_back(w[31:24]);
    end
    tick();
    sample_avail = 0;
  endtask
  task automatic wb_write(input logic [1:0] a, input logic [7:0] d);
    wb_adr_i = {14'b0, a};
    wb_dat_i = d;
    wb_cyc_i = 1;
    wb_stb_i = 1;
    wb_we_i = 1;
    tick();
    wb_cyc_i = 0;
    wb_stb_i = 0;
    wb_we_i = 0;
  endtask
  task automatic wb_read(input string name, input logic [1:0] a, input logic [7:0] exp);
    wb_adr_i = {14'b0, a};
    #1;
    check(name, wb_dat_o, exp);
  endtask
  task automatic wait_drain(input string name, input int max_cycles);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < max_cycles) begin
      tick();
      n++;
    end
    check(name, {31'b0, exp_q.size() == 0 && !out_valid}, 32'd1);
  endtask
  function automatic logic [31:0] word(input int i);
    return {i[15:0] ^ 16'h5A00, ~i[15:0]};
  endfunction
  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end
  initial begin
    repeat (3) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_sq_active", sq_active, 0);
    check("wb_ack", wb_ack_o, 1);
    wb_read("rst_status", 2'd0, 8'h00);
    wb_read("rst_fill", 2'd1, 8'h00);
    wb_read("rst_ovf_lo", 2'd2, 8'h00);
    rst = 0;
    tick();
    // basic word, latency and byte order
    wb_write(2'd0, 8'h01);
    check("activate", sq_active, 1);
    out_ready = 1;
    push_word(32'h44332211, 1);
    check("lat_cycle0", out_valid, 0);
    tick();
    check("lat_cycle1", out_valid, 0);
    tick();
    check("lat_cycle2_valid", out_valid, 1);
    check("lat_cycle2_data", out_data, 8'h11);
    wait_drain("drain_basic", 50);
    wb_read("fill_after_basic", 2'd1, 8'h00);
    // overflow: one word sits in the serializer, DEPTH in RAM, the last three drop
    out_ready = 0;
    for (int i = 0; i < DEPTH + 4; i++) push_word(word(i), i < DEPTH + 1);
    wb_read("ovf_status", 2'd0, 8'h03);
    wb_read("ovf_fill_sat", 2'd1, 8'hFF);
`ifdef SAMPQ_OVERFLOW_COUNT_EN
    wb_read("ovf_cnt_lo", 2'd2, 8'h03);
`else
    wb_read("ovf_cnt_lo", 2'd2, 8'h00);
`endif
    wb_read("ovf_cnt_hi", 2'd3, 8'h00);
    out_ready = 1;
    wait_drain("drain_full", 4000);
    wb_read("fill_after_full", 2'd1, 8'h00);
    // push coinciding with the read-pointer advance keeps fill at 5
    out_ready = 0;
    for (int i = 0; i < 6; i++) push_word(32'hC0DE0000 + i, 1);
    wb_read("fill5", 2'd1, 8'h02);
    out_ready = 1;
    repeat (4) tick();
    out_ready = 0;
    push_word(32'hC0DE0006, 1);
    wb_read("fill5_after_simul", 2'd1, 8'h02);
    push_word(32'hC0DE0007, 1);
    wb_read("fill6", 2'd1, 8'h03);
    out_ready = 1;
    wait_drain("drain_simul", 200);
    // pointer wrap
    for (int i = 0; i < DEPTH + 10; i++) begin
      push_word(word(i + 1000), 1);
      repeat (5) tick();
    end
    wait_drain("drain_wrap", 200);
    // stall toggling
    out_ready = 0;
    push_word(32'hDDCCBBAA, 1);
    repeat (2) tick();
    check("toggle_valid", out_valid, 1);
    for (int i = 0; i < 7; i++) begin
      out_ready = (i % 2) == 0;
      tick();
    end
    wait_drain("drain_toggle", 20);
    // stop then flush
    out_ready = 0;
    for (int i = 0; i < 7; i++) push_word(32'hF1000000 + i, 1);
    wb_read("fill_pre_flush", 2'd1, 8'h03);
    wb_write(2'd0, 8'h00);
    check("deactivate", sq_active, 0);
    wb_write(2'd0, 8'h02);
    exp_q.delete();
    check("flush_valid", out_valid, 0);
    wb_read("flush_fill", 2'd1, 8'h00);
    wb_read("flush_status", 2'd0, 8'h02);
    wb_write(2'd0, 8'h01);
    wb_read("rearm_status", 2'd0, 8'h01);
    wb_read("rearm_cnt_lo", 2'd2, 8'h00);
    wb_read("rearm_cnt_hi", 2'd3, 8'h00);
    out_ready = 1;
    repeat (10) tick();
    check("flush_no_bytes", out_valid, 0);
    // reset in the middle of a word
    out_ready = 0;
    for (int i = 0; i < 4; i++) push_word(32'hB0B0B000 + i, 1);
    wb_read("fill_pre_rst", 2'd1, 8'h01);
    out_ready = 1;
    repeat (2) tick();
    out_ready = 0;
    rst = 1;
    tick();
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_active", sq_active, 0);
    wb_read("rst_mid_fill", 2'd1, 8'h00);
    exp_q.delete();
    rst = 0;
    out_ready = 1;
    repeat (20) tick();
    check("post_rst_idle", out_valid, 0);
    // inactive queue still accepts a late sample
    push_word(32'h87654321, 1);
    wait_drain("drain_late", 50);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
